// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings, control types and forwarding helper for the pipeline core
package cpu_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRA  = 3'b101;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ALU_AND, ALU_XOR, ALU_SLL, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SRA
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    // The younger producer (EX/MEM) wins over MEM/WB.
    function automatic fwd_sel_e fwd_pick(input logic [4:0] rs,
                                          input logic       em_we,
                                          input logic [4:0] em_rd,
                                          input logic       mw_we,
                                          input logic [4:0] mw_rd);
        if (em_we && em_rd != 5'd0 && em_rd == rs) return FWD_MEM;
        if (mw_we && mw_rd != 5'd0 && mw_rd == rs) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - load-use stall detection and EX operand forwarding select
module pipeline_hazard_unit import cpu_pkg::*; (
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rd_i,
    input  logic [4:0] idex_rs1_i,
    input  logic [4:0] idex_rs2_i,
    input  logic [4:0] ifid_rs1_i,
    input  logic [4:0] ifid_rs2_i,
    input  logic       exmem_reg_write_i,
    input  logic [4:0] exmem_rd_i,
    input  logic       memwb_reg_write_i,
    input  logic [4:0] memwb_rd_i,
    output logic       stall_o,
    output logic       pc_write_o,
    output fwd_sel_e   fwd_a_o,
    output fwd_sel_e   fwd_b_o
);

    always_comb begin
        stall_o    = idex_mem_read_i && (idex_rd_i != 5'd0) &&
                     ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
        pc_write_o = !stall_o;
        fwd_a_o    = fwd_pick(idex_rs1_i, exmem_reg_write_i, exmem_rd_i,
                              memwb_reg_write_i, memwb_rd_i);
        fwd_b_o    = fwd_pick(idex_rs2_i, exmem_reg_write_i, exmem_rd_i,
                              memwb_reg_write_i, memwb_rd_i);
    end

endmodule

// File: rtl/pipeline_cpu.sv
// rtl/pipeline_cpu.sv - five-stage in-order RV32I-subset core with forwarding, load-use stall and ID-resolved beq
module pipeline_cpu import cpu_pkg::*; #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 32,
    parameter int XLEN       = 32
) (
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);

    localparam int IA_W = $clog2(IMEM_WORDS);
    localparam int DA_W = $clog2(DMEM_WORDS);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } ifid_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } idex_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            mem_to_reg;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
    } exmem_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_to_reg;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] mem_data;
        logic [4:0]      rd;
    } memwb_t;

    logic [XLEN-1:0] imem [0:IMEM_WORDS-1];
    logic [XLEN-1:0] dmem [0:DMEM_WORDS-1];
    logic [XLEN-1:0] regs [0:31];

    logic [XLEN-1:0] pc_q, pc_d;
    ifid_t  ifid_q, ifid_d;
    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic      stall, pc_write, branch_taken;
    fwd_sel_e  fwd_a, fwd_b;

    logic [6:0]      id_opcode, id_funct7;
    logic [2:0]      id_funct3;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_val, id_rs2_val, id_imm, branch_target;
    ctrl_t           id_ctrl;
    logic            id_is_beq;

    logic [XLEN-1:0] ex_a, ex_b_reg, ex_b, alu_res, mem_rdata, wb_data;
    alu_ctrl_e       alu_ctrl;
    logic            wb_we;

    assign id_opcode = ifid_q.instr[6:0];
    assign id_rd     = ifid_q.instr[11:7];
    assign id_funct3 = ifid_q.instr[14:12];
    assign id_rs1    = ifid_q.instr[19:15];
    assign id_rs2    = ifid_q.instr[24:20];
    assign id_funct7 = ifid_q.instr[31:25];

    assign wb_we   = memwb_q.reg_write && (memwb_q.rd != 5'd0);
    assign wb_data = memwb_q.mem_to_reg ? memwb_q.mem_data : memwb_q.alu_res;

    // Write-through lets WB and ID share a cycle without a separate bypass.
    assign id_rs1_val = (id_rs1 == 5'd0) ? '0 :
                        (wb_we && memwb_q.rd == id_rs1) ? wb_data : regs[id_rs1];
    assign id_rs2_val = (id_rs2 == 5'd0) ? '0 :
                        (wb_we && memwb_q.rd == id_rs2) ? wb_data : regs[id_rs2];

    always_comb begin
        id_ctrl   = '0;
        id_imm    = '0;
        id_is_beq = 1'b0;
        case (id_opcode)
            OPC_RTYPE: begin
                if ((id_funct7 == F7_BASE && (id_funct3 == F3_AND || id_funct3 == F3_XOR ||
                                              id_funct3 == F3_SLL || id_funct3 == F3_ADD)) ||
                    ((id_funct7 == F7_ALT || id_funct7 == F7_MULDIV) && id_funct3 == F3_ADD)) begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_op    = ALUOP_RTYPE;
                end
            end
            OPC_OPIMM: begin
                id_imm = {{(XLEN-12){ifid_q.instr[31]}}, ifid_q.instr[31:20]};
                if (id_funct3 == F3_ADD || (id_funct3 == F3_SRA && id_funct7 == F7_ALT)) begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_src   = 1'b1;
                    id_ctrl.alu_op    = ALUOP_ITYPE;
                end
            end
            OPC_LOAD: begin
                id_imm = {{(XLEN-12){ifid_q.instr[31]}}, ifid_q.instr[31:20]};
                if (id_funct3 == F3_WORD) begin
                    id_ctrl.reg_write  = 1'b1;
                    id_ctrl.mem_read   = 1'b1;
                    id_ctrl.mem_to_reg = 1'b1;
                    id_ctrl.alu_src    = 1'b1;
                end
            end
            OPC_STORE: begin
                id_imm = {{(XLEN-12){ifid_q.instr[31]}}, ifid_q.instr[31:25], ifid_q.instr[11:7]};
                if (id_funct3 == F3_WORD) begin
                    id_ctrl.mem_write = 1'b1;
                    id_ctrl.alu_src   = 1'b1;
                end
            end
            OPC_BRANCH: begin
                id_imm = {{(XLEN-13){ifid_q.instr[31]}}, ifid_q.instr[31], ifid_q.instr[7],
                          ifid_q.instr[30:25], ifid_q.instr[11:8], 1'b0};
                id_is_beq = (id_funct3 == F3_BEQ);
            end
            default: ;
        endcase
    end

    pipeline_hazard_unit u_hazard (
        .idex_mem_read_i   (idex_q.ctrl.mem_read),
        .idex_rd_i         (idex_q.rd),
        .idex_rs1_i        (idex_q.rs1),
        .idex_rs2_i        (idex_q.rs2),
        .ifid_rs1_i        (id_rs1),
        .ifid_rs2_i        (id_rs2),
        .exmem_reg_write_i (exmem_q.reg_write),
        .exmem_rd_i        (exmem_q.rd),
        .memwb_reg_write_i (memwb_q.reg_write),
        .memwb_rd_i        (memwb_q.rd),
        .stall_o           (stall),
        .pc_write_o        (pc_write),
        .fwd_a_o           (fwd_a),
        .fwd_b_o           (fwd_b)
    );

    // A pending stall defers the branch; it re-evaluates once the load has moved on.
    assign branch_taken  = id_is_beq && (id_rs1_val == id_rs2_val) && !stall && start_i;
    assign branch_target = ifid_q.pc + id_imm;

    always_comb begin
        case (fwd_a)
            FWD_MEM: ex_a = exmem_q.alu_res;
            FWD_WB:  ex_a = wb_data;
            default: ex_a = idex_q.rs1_val;
        endcase
        case (fwd_b)
            FWD_MEM: ex_b_reg = exmem_q.alu_res;
            FWD_WB:  ex_b_reg = wb_data;
            default: ex_b_reg = idex_q.rs2_val;
        endcase
        ex_b = idex_q.ctrl.alu_src ? idex_q.imm : ex_b_reg;
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (idex_q.ctrl.alu_op)
            ALUOP_BRANCH: alu_ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (idex_q.funct3)
                    F3_AND:  alu_ctrl = ALU_AND;
                    F3_XOR:  alu_ctrl = ALU_XOR;
                    F3_SLL:  alu_ctrl = ALU_SLL;
                    default: alu_ctrl = (idex_q.funct7 == F7_ALT)    ? ALU_SUB :
                                        (idex_q.funct7 == F7_MULDIV) ? ALU_MUL : ALU_ADD;
                endcase
            end
            ALUOP_ITYPE: alu_ctrl = (idex_q.funct3 == F3_SRA) ? ALU_SRA : ALU_ADD;
            default: ;
        endcase
    end

    always_comb begin
        case (alu_ctrl)
            ALU_AND: alu_res = ex_a & ex_b;
            ALU_XOR: alu_res = ex_a ^ ex_b;
            ALU_SLL: alu_res = ex_a << ex_b[4:0];
            ALU_SUB: alu_res = ex_a - ex_b;
            ALU_MUL: alu_res = ex_a * ex_b;
            ALU_SRA: alu_res = $signed(ex_a) >>> ex_b[4:0];
            default: alu_res = ex_a + ex_b;
        endcase
    end

    assign mem_rdata = dmem[exmem_q.alu_res[DA_W+1:2]];

    // With start_i low IF/ID holds and bubbles drain the back end, so nothing is lost or replayed.
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (start_i && pc_write) begin
            pc_d         = branch_taken ? branch_target : pc_q + XLEN'(4);
            ifid_d.pc    = pc_q;
            ifid_d.instr = imem[pc_q[IA_W+1:2]];
            if (branch_taken) ifid_d = '0;
        end

        idex_d         = '0;
        idex_d.rs1_val = id_rs1_val;
        idex_d.rs2_val = id_rs2_val;
        idex_d.imm     = id_imm;
        idex_d.rs1     = id_rs1;
        idex_d.rs2     = id_rs2;
        idex_d.rd      = id_rd;
        idex_d.funct3  = id_funct3;
        idex_d.funct7  = id_funct7;
        if (start_i && !stall) idex_d.ctrl = id_ctrl;

        exmem_d.reg_write  = idex_q.ctrl.reg_write;
        exmem_d.mem_write  = idex_q.ctrl.mem_write;
        exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
        exmem_d.alu_res    = alu_res;
        exmem_d.store_data = ex_b_reg;
        exmem_d.rd         = idex_q.rd;

        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.alu_res    = exmem_q.alu_res;
        memwb_d.mem_data   = mem_rdata;
        memwb_d.rd         = exmem_q.rd;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (exmem_q.mem_write) dmem[exmem_q.alu_res[DA_W+1:2]] <= exmem_q.store_data;
        if (wb_we) regs[memwb_q.rd] <= wb_data;
    end

endmodule

// File: tb/tb_pipeline_cpu.sv
// tb/tb_pipeline_cpu.sv - directed programs with a result scoreboard for pipeline_cpu
module tb_pipeline_cpu;

    logic clk_i = 1'b0;
    logic rst_i;
    logic start_i;

    always #5 clk_i = ~clk_i;

    pipeline_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(32), .XLEN(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i)
    );

    localparam int K_REG = 0, K_MEM = 1, K_STALL = 2, K_FLUSH = 3, K_HOLD = 4;

    int n_assert = 0;
    int n_fail   = 0;
    int stall_cnt, flush_cnt, hold_cnt;

    logic [31:0] prog [$];
    logic [31:0] exp_pc [$];
    string       sb_tag [$];
    int          sb_kind [$];
    int          sb_idx [$];
    logic [31:0] sb_val [$];

    function automatic logic [31:0] op_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] op_i(input int imm, input int f3, input int rd, input int rs1, input int opc);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
    endfunction

    function automatic logic [31:0] op_s(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] op_b(input int imm, input int rs1, input int rs2);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return op_i(imm, 0, rd, rs1, 'h13);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int kind, input int idx, input logic [31:0] val);
        sb_tag.push_back(tag);
        sb_kind.push_back(kind);
        sb_idx.push_back(idx);
        sb_val.push_back(val);
    endtask

    task automatic sb_check_all();
        logic [31:0] obs;
        int k, i;
        while (sb_kind.size() > 0) begin
            k = sb_kind.pop_front();
            i = sb_idx.pop_front();
            case (k)
                K_REG:   obs = dut.regs[i];
                K_MEM:   obs = dut.dmem[i];
                K_STALL: obs = 32'(stall_cnt);
                K_FLUSH: obs = 32'(flush_cnt);
                default: obs = 32'(hold_cnt);
            endcase
            check(sb_tag.pop_front(), obs, sb_val.pop_front());
        end
    endtask

    task automatic reset_dut();
        start_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
        for (int i = 0; i < 32; i++) dut.dmem[i] = 32'h0;
        for (int i = 0; i < 32; i++) dut.regs[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic run(input int n);
        logic [31:0] prev;
        stall_cnt = 0;
        flush_cnt = 0;
        hold_cnt  = 0;
        start_i   = 1'b1;
        prev      = dut.pc_q;
        for (int c = 0; c < n; c++) begin
            @(negedge clk_i);
            if (dut.stall === 1'b1) stall_cnt++;
            if (dut.branch_taken === 1'b1) flush_cnt++;
            @(posedge clk_i); #1;
            if (dut.pc_q == prev) hold_cnt++;
            prev = dut.pc_q;
        end
        start_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;

        // Reset and free-running fetch of an all-zero program
        prog.delete();
        reset_dut();
        dut.regs[5] = 32'h0000_1234;
        dut.dmem[3] = 32'h0000_cafe;
        check("reset_pc", dut.pc_q, 32'h0);
        check("reset_ifid_instr", dut.ifid_q.instr, 32'h0);
        check("reset_memwb_regwrite", 32'(dut.memwb_q.reg_write), 32'h0);
        for (int i = 1; i <= 5; i++) exp_pc.push_back(32'(4 * i));
        start_i = 1'b1;
        while (exp_pc.size() > 0) begin
            @(posedge clk_i); #1;
            check("fetch_pc", dut.pc_q, exp_pc.pop_front());
        end
        start_i = 1'b0;
        repeat (3) exp_pc.push_back(32'd20);
        while (exp_pc.size() > 0) begin
            @(posedge clk_i); #1;
            check("frozen_pc", dut.pc_q, exp_pc.pop_front());
        end
        check("nop_x5_kept", dut.regs[5], 32'h0000_1234);
        check("nop_x1_kept", dut.regs[1], 32'h0);
        check("nop_dmem3_kept", dut.dmem[3], 32'h0000_cafe);

        // ALU ops with back-to-back dependencies
        prog = {addi(1, 0, 10), addi(2, 0, 3), op_r(0, 0, 3, 1, 2), op_r(32, 0, 4, 3, 2),
                op_r(1, 0, 5, 1, 2), op_r(0, 4, 6, 1, 2), op_r(0, 7, 7, 1, 2)};
        reset_dut();
        sb_push("alu_add_x3", K_REG, 3, 32'd13);
        sb_push("alu_sub_x4", K_REG, 4, 32'd10);
        sb_push("alu_mul_x5", K_REG, 5, 32'd30);
        sb_push("alu_xor_x6", K_REG, 6, 32'd9);
        sb_push("alu_and_x7", K_REG, 7, 32'd2);
        sb_push("alu_x0_zero", K_REG, 0, 32'd0);
        sb_push("alu_stalls", K_STALL, 0, 32'd0);
        run(14);
        sb_check_all();

        // Shifts
        prog = {addi(1, 0, -16), op_i('h402, 5, 2, 1, 'h13), addi(3, 0, 1), op_r(0, 1, 4, 3, 2)};
        reset_dut();
        sb_push("shift_x1", K_REG, 1, 32'hffff_fff0);
        sb_push("shift_srai_x2", K_REG, 2, 32'hffff_fffc);
        sb_push("shift_sll_x4", K_REG, 4, 32'h1000_0000);
        run(12);
        sb_check_all();

        // Load-use
        prog = {op_i(0, 2, 1, 0, 'h03), op_r(0, 0, 2, 1, 1), op_s(4, 2, 0)};
        reset_dut();
        dut.dmem[0] = 32'd5;
        sb_push("lu_x1", K_REG, 1, 32'd5);
        sb_push("lu_x2", K_REG, 2, 32'd10);
        sb_push("lu_dmem4", K_MEM, 1, 32'd10);
        sb_push("lu_stalls", K_STALL, 0, 32'd1);
        sb_push("lu_pc_holds", K_HOLD, 0, 32'd1);
        run(12);
        sb_check_all();

        // Branch taken
        prog = {addi(1, 0, 1), 32'h13, 32'h13, op_b(8, 1, 1), addi(6, 0, 7), addi(7, 0, 9)};
        reset_dut();
        sb_push("bt_x6", K_REG, 6, 32'd0);
        sb_push("bt_x7", K_REG, 7, 32'd9);
        sb_push("bt_flushes", K_FLUSH, 0, 32'd1);
        run(14);
        sb_check_all();

        // Branch not taken
        prog = {addi(1, 0, 1), 32'h13, 32'h13, op_b(8, 1, 0), addi(6, 0, 7), addi(7, 0, 9)};
        reset_dut();
        sb_push("bnt_x6", K_REG, 6, 32'd7);
        sb_push("bnt_x7", K_REG, 7, 32'd9);
        sb_push("bnt_flushes", K_FLUSH, 0, 32'd0);
        run(14);
        sb_check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_cpu.md
Name: pipeline_cpu

Overview:
- Five-stage in-order RV32I-subset pipeline: IF, ID, EX, MEM, WB.
- Contains PC, instruction memory, register file, control, immediate generator, ALU, data memory and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Hazard handling: EX-stage forwarding, one-cycle load-use stall, and beq resolved in ID with a one-slot flush.
- Top-level core of the lab system. The bench preloads memories and the register file hierarchically.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words, indexed by PC[9:2].
- DMEM_WORDS, 32, data memory depth in 32-bit words, indexed by address[6:2].
- XLEN, 32, datapath width.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  run enable. PC advances only when high.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - PC=0.
  - Every pipeline-register field cleared to 0, so all control bits are 0 (bubbles).
  - Register file, instruction memory and data memory are NOT reset.
- PC update:
  - Updates when start_i=1 and PCWrite=1.
  - Next PC = branch target if beq is taken in ID, otherwise PC+4.
  - start_i=0 holds PC.
- Supported ISA (all other encodings are treated as nop, with no writes):
  - R-type, opcode 0110011, funct7/funct3:
    - and 0000000/111
    - xor 0000000/100
    - sll 0000000/001 (shift by rs2[4:0])
    - add 0000000/000
    - sub 0100000/000
    - mul 0000001/000 (low 32 bits)
  - addi: opcode 0010011, funct3 000.
  - srai: opcode 0010011, funct3 101, imm[11:5]=0100000; arithmetic shift by imm[4:0].
  - lw: opcode 0000011, funct3 010.
  - sw: opcode 0100011, funct3 010.
  - beq: opcode 1100011, funct3 000.
- Immediates are sign-extended. Branch target = IF/ID.PC + (B-imm<<1).
- Register file:
  - 2 read ports, 1 write port; x0 reads 0 and is never written.
  - Write-through: a WB write to the register being read in the same cycle returns the new value.
- Forwarding (EX operands):
  - Forward from EX/MEM when EX/MEM.RegWrite and Rd!=0 and Rd==Rs.
  - Else forward from MEM/WB under the same conditions.
  - Else use the register value.
  - Forwarding also applies to the sw store data.
- Load-use hazard:
  - Condition: ID/EX.MemRead and ID/EX.Rd!=0 and ID/EX.Rd equals IF/ID Rs1 or Rs2.
  - Response, for exactly one cycle: Stall=1, PCWrite=0, IF/ID held, ID/EX control zeroed.
- beq:
  - Compares register-file outputs in ID; there is no forwarding into ID.
  - Taken: PC loads the target and IF/ID is flushed to 0 (a nop) on the next edge. Penalty is 1 cycle.
  - If a load-use stall and a taken branch coincide, the stall takes priority; the branch re-evaluates the following cycle.
- Memory timing:
  - Data memory read is combinational.
  - Data memory write is on the clock edge when EX/MEM.MemWrite=1.
  - Word-aligned accesses only; address bits [1:0] are ignored.
- Latency: an ALU result is architecturally visible in the register file 4 edges after fetch+1.
- Observability: the internal Stall, PCWrite and branch-taken (flush) signals must remain named nets so the bench can count stalls and flushes.

Decomposition:
- Shared package cpu_pkg: opcode constants, funct3/funct7 constants, ALU-control enum (AND, XOR, SLL, ADD, SUB, MUL, SRA), 2-bit ALUOp encoding.
- Natural sub-module: pipeline_hazard_unit, containing the load-use detection and forwarding-select logic.

Test Plan:
- Reset/fetch:
  - Stimulus: rst_i=1 for one edge, then start_i=1 with an all-zero program.
  - Required: PC=0,4,8,… each cycle; no register or memory changes.
  - start_i=0 freezes PC.
- ALU + forwarding:
  - Program: addi x1,x0,10; addi x2,x0,3; add x3,x1,x2; sub x4,x3,x2; mul x5,x1,x2; xor x6,x1,x2; and x7,x1,x2.
  - Required: x3=13, x4=10, x5=30, x6=9, x7=2; zero stalls.
- Shifts:
  - Program: addi x1,x0,-16; srai x2,x1,2; addi x3,x0,1; sll x4,x3,x2.
  - Required: x2=-4, x4=0x10000000 (shift 28).
- Load-use:
  - Setup: DMem[0]=5.
  - Program: lw x1,0(x0); add x2,x1,x1; sw x2,4(x0).
  - Required: x2=10, DMem[0x04]=10, stall count=1, PC held exactly one cycle.
- Branch taken:
  - Program: addi x1,x0,1; nop; nop; beq x1,x1,8; addi x6,x0,7; addi x7,x0,9.
  - Required: x6=0, x7=9, flush count=1.
- Branch not taken:
  - Program: the same sequence with beq x1,x0.
  - Required: x6=7, x7=9, flush count=0.
